// File: rtl/mul1024_pkg.sv
// Shared types and constants for the 1024-bit multiplier arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul1024_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int NUM_REQ_DEF        = 4;
  localparam int TIMEOUT_CYCLES_DEF = 8192;
  localparam int CNT_W_DEF          = 13;

  // Core handshake polarities: load is an active-low start strobe,
  // enable high lets the core run (low clears its internal counters).
  localparam logic LOAD_START = 1'b0;
  localparam logic ENABLE_RUN = 1'b1;

endpackage

// File: rtl/mul1024_arbiter_if.sv
// Requester and multiplier-core handshake bundle for the arbiter.
// Latency: n/a (wires only).
// Backpressure: level requests held until their one-cycle ack.
interface mul1024_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] iReq;
  logic [NUM_REQ-1:0] oGrant;
  logic [ID_W-1:0]    oGrantId;
  logic [NUM_REQ-1:0] oAck;
  logic               oErr;
  logic               oBusy;
  logic               oMulEnable;
  logic               oMulLoad;
  logic               iMulDataValid;

  modport slave (
    input  iReq, iMulDataValid,
    output oGrant, oGrantId, oAck, oErr, oBusy, oMulEnable, oMulLoad
  );

  modport master (
    output iReq, iMulDataValid,
    input  oGrant, oGrantId, oAck, oErr, oBusy, oMulEnable, oMulLoad
  );
endinterface

// File: rtl/mul1024_arbiter_rr_pick.sv
// Round-robin winner select: searches upward from lastId+1 with wrap.
// Latency: purely combinational.
// Backpressure: none; caller decides when to accept the winner.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] iReqVec,
  input  logic [ID_W-1:0]    iLastId,
  output logic [NUM_REQ-1:0] oWinOneHot,
  output logic [ID_W-1:0]    oWinId,
  output logic               oAnyVld
);

  logic [ID_W-1:0] idx;

  // First requester found after the last winner takes the grant.
  always_comb begin
    oWinOneHot = '0;
    oWinId     = '0;
    oAnyVld    = 1'b0;
    idx        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(iLastId) + i) % NUM_REQ);
      if (!oAnyVld && iReqVec[idx]) begin
        oAnyVld         = 1'b1;
        oWinId          = idx;
        oWinOneHot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul1024_arbiter.sv
// Shares one 1024-bit serial multiplier between requesters: clear, start, wait, ack.
// Latency: request to start pulse 2 cycles; data-valid to ack 1 cycle; watchdog aborts.
// Backpressure: requests wait in IDLE; one job at a time, new requests arbitrated after ack.
module mul1024_arbiter
  import mul1024_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input logic              iClk,
  input logic              iRst_n,
  mul1024_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t             state;
  state_t             stateNxt;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grantId;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   wdCnt;
  logic               errFlag;
  logic               wdHit;
  logic [NUM_REQ-1:0] pickOneHot;
  logic [ID_W-1:0]    pickId;
  logic               pickAny;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) uPick (
    .iReqVec   (bus.iReq),
    .iLastId   (ptr),
    .oWinOneHot(pickOneHot),
    .oWinId    (pickId),
    .oAnyVld   (pickAny)
  );

  assign wdHit = (wdCnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register; reset drops any in-flight job without an ack.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= stateNxt;
  end

  // Next state plus output decode, all from registered state only.
  always_comb begin
    stateNxt       = state;
    bus.oMulEnable = ~ENABLE_RUN;
    bus.oMulLoad   = ~LOAD_START;
    bus.oBusy      = (state != IDLE);
    bus.oAck       = '0;
    bus.oErr       = 1'b0;
    bus.oGrant     = grant;
    bus.oGrantId   = grantId;
    case (state)
      IDLE:  if (pickAny) stateNxt = CLEAR;
      CLEAR: stateNxt = START;
      START: begin
        bus.oMulEnable = ENABLE_RUN;
        bus.oMulLoad   = LOAD_START;
        stateNxt       = BUSY;
      end
      BUSY: begin
        bus.oMulEnable = ENABLE_RUN;
        if (bus.iMulDataValid || wdHit) stateNxt = DONE;
      end
      DONE: begin
        bus.oAck = grant;
        bus.oErr = errFlag;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Grant latch, watchdog, timeout flag and round-robin pointer.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      grant   <= '0;
      grantId <= '0;
      ptr     <= ID_W'(NUM_REQ - 1);
      wdCnt   <= '0;
      errFlag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pickAny) begin
            grant   <= pickOneHot;
            grantId <= pickId;
          end
        end
        START: begin
          wdCnt   <= '0;
          errFlag <= 1'b0;
        end
        BUSY: begin
          wdCnt <= wdCnt + 1'b1;
          // A valid arriving on the timeout cycle still counts as success.
          if (!bus.iMulDataValid && wdHit) errFlag <= 1'b1;
        end
        DONE: begin
          ptr   <= grantId;
          grant <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul1024_arbiter.sv
// Directed bench: reset, single long job, fairness, mid-job drop, stray valid, timeout races.
// Latency: n/a.
// Backpressure: n/a.
module tb_mul1024_arbiter;

  logic iClk;
  logic iRst_n;
  int   checks;
  int   failures;

  mul1024_arbiter_if #(.NUM_REQ(4)) busA ();
  mul1024_arbiter_if #(.NUM_REQ(4)) busB ();

  mul1024_arbiter #(
    .NUM_REQ(4), .TIMEOUT_CYCLES(8192), .CNT_W(13)
  ) dutA (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .bus   (busA)
  );

  mul1024_arbiter #(
    .NUM_REQ(4), .TIMEOUT_CYCLES(100), .CNT_W(7)
  ) dutB (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .bus   (busB)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(negedge iClk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the start pulse on each DUT.
  task automatic waitStartA(input string tag);
    int n;
    n = 0;
    while (busA.oMulLoad !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(busA.oMulLoad), 32'h0);
  endtask

  task automatic waitStartB(input string tag);
    int n;
    n = 0;
    while (busB.oMulLoad !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(busB.oMulLoad), 32'h0);
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    iRst_n             = 1'b0;
    busA.iReq          = 4'b0000;
    busA.iMulDataValid = 1'b0;
    busB.iReq          = 4'b0000;
    busB.iMulDataValid = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_grant",   32'(busA.oGrant),     32'h0);
    chk("rst_ack",     32'(busA.oAck),       32'h0);
    chk("rst_err",     32'(busA.oErr),       32'h0);
    chk("rst_busy",    32'(busA.oBusy),      32'h0);
    chk("rst_enable",  32'(busA.oMulEnable), 32'h0);
    chk("rst_load",    32'(busA.oMulLoad),   32'h1);
    chk("rst_grantid", 32'(busA.oGrantId),   32'h0);
    iRst_n = 1'b1;
    tick();

    // Single long job from requester 2
    busA.iReq = 4'b0100;
    tick();
    chk("single_clear_grant",  32'(busA.oGrant),     32'h4);
    chk("single_clear_busy",   32'(busA.oBusy),      32'h1);
    chk("single_clear_enable", 32'(busA.oMulEnable), 32'h0);
    chk("single_clear_load",   32'(busA.oMulLoad),   32'h1);
    tick();
    chk("single_start_load",   32'(busA.oMulLoad),   32'h0);
    chk("single_start_enable", 32'(busA.oMulEnable), 32'h1);
    tick();
    chk("single_busy_load",    32'(busA.oMulLoad),   32'h1);
    chk("single_busy_enable",  32'(busA.oMulEnable), 32'h1);
    repeat (1985) tick();
    chk("single_still_busy",   32'(busA.oMulEnable), 32'h1);
    chk("single_no_early_ack", 32'(busA.oAck),       32'h0);
    busA.iMulDataValid = 1'b1;
    tick();
    chk("single_done_ack",     32'(busA.oAck),       32'h4);
    chk("single_done_err",     32'(busA.oErr),       32'h0);
    chk("single_done_enable",  32'(busA.oMulEnable), 32'h0);
    chk("single_done_id",      32'(busA.oGrantId),   32'h2);
    chk("single_done_grant",   32'(busA.oGrant),     32'h4);
    busA.iMulDataValid = 1'b0;
    busA.iReq          = 4'b0000;
    tick();
    chk("single_idle_busy",    32'(busA.oBusy),      32'h0);
    chk("single_idle_ack",     32'(busA.oAck),       32'h0);
    chk("single_idle_grant",   32'(busA.oGrant),     32'h0);
    chk("single_idle_id_kept", 32'(busA.oGrantId),   32'h2);

    // Reset mid-BUSY: pointer sits at 2, so requester 3 is being served
    busA.iReq = 4'b1111;
    waitStartA("midrst_start_seen");
    chk("midrst_grant", 32'(busA.oGrant), 32'h8);
    tick();
    tick();
    iRst_n = 1'b0;
    #1;
    chk("midrst_grant0",  32'(busA.oGrant),     32'h0);
    chk("midrst_busy0",   32'(busA.oBusy),      32'h0);
    chk("midrst_enable0", 32'(busA.oMulEnable), 32'h0);
    chk("midrst_load1",   32'(busA.oMulLoad),   32'h1);
    chk("midrst_id0",     32'(busA.oGrantId),   32'h0);
    chk("midrst_ack0",    32'(busA.oAck),       32'h0);
    tick();
    iRst_n = 1'b1;

    // Fairness with all four requesting: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      waitStartA($sformatf("fair_start%0d", k));
      chk($sformatf("fair_grant%0d", k), 32'(busA.oGrant), 32'd1 << (k % 4));
      chk($sformatf("fair_id%0d", k), 32'(busA.oGrantId), 32'(k % 4));
      repeat (40) tick();
      busA.iMulDataValid = 1'b1;
      tick();
      chk($sformatf("fair_ack%0d", k), 32'(busA.oAck), 32'd1 << (k % 4));
      chk($sformatf("fair_err%0d", k), 32'(busA.oErr), 32'h0);
      busA.iMulDataValid = 1'b0;
      if (k == 4) busA.iReq = 4'b0000;
      tick();
      chk($sformatf("fair_ack_off%0d", k), 32'(busA.oAck), 32'h0);
    end

    // Requester 1 drops its request mid-job and still gets the ack
    busA.iReq = 4'b0010;
    waitStartA("drop_start_seen");
    chk("drop_grant", 32'(busA.oGrant), 32'h2);
    tick();
    busA.iReq = 4'b0000;
    repeat (5) tick();
    chk("drop_grant_held", 32'(busA.oGrant), 32'h2);
    busA.iMulDataValid = 1'b1;
    tick();
    chk("drop_ack", 32'(busA.oAck), 32'h2);
    busA.iMulDataValid = 1'b0;
    tick();
    chk("drop_idle", 32'(busA.oBusy), 32'h0);

    // Stray valid while idle is ignored
    busA.iMulDataValid = 1'b1;
    tick();
    busA.iMulDataValid = 1'b0;
    chk("stray_busy", 32'(busA.oBusy), 32'h0);
    chk("stray_ack",  32'(busA.oAck),  32'h0);
    tick();
    chk("stray_busy2", 32'(busA.oBusy), 32'h0);

    // Timeout (100 cycles): ack+err exactly 101 cycles after START
    busB.iReq = 4'b0001;
    waitStartB("tmo_start_seen");
    repeat (100) tick();
    chk("tmo_no_ack_at_100", 32'(busB.oAck), 32'h0);
    chk("tmo_busy_at_100",   32'(busB.oMulEnable), 32'h1);
    tick();
    chk("tmo_ack", 32'(busB.oAck), 32'h1);
    chk("tmo_err", 32'(busB.oErr), 32'h1);
    busB.iReq = 4'b0000;
    tick();
    chk("tmo_idle_busy", 32'(busB.oBusy), 32'h0);
    chk("tmo_idle_err",  32'(busB.oErr),  32'h0);

    // Valid on the same cycle the watchdog reaches 99: success wins
    busB.iReq = 4'b0001;
    waitStartB("race_start_seen");
    repeat (100) tick();
    busB.iMulDataValid = 1'b1;
    tick();
    chk("race_ack", 32'(busB.oAck), 32'h1);
    chk("race_err", 32'(busB.oErr), 32'h0);
    busB.iMulDataValid = 1'b0;
    busB.iReq          = 4'b0000;
    tick();
    chk("race_idle", 32'(busB.oBusy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
